seq1101_tx: RTL and testbench

Serial frame transmitter producing the bit stream a non-overlapping `1101` Mealy detector consumes. It accepts a parallel word over a valid/ready handshake and emits a sync header (`1101`), then the payload MSB-first, then an even-parity bit, one bit per clock. Zero-stuffing in the payload and parity region prevents `1101` from appearing after the header. It sits between the parallel datapath and the single-wire serial link.

---
 rtl/seq1101_pkg.sv | 12 +
 rtl/seq1101_stuff_ctl.sv | 27 ++
 rtl/seq1101_tx.sv | 121 ++++++++++++
 tb/tb_seq1101_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq1101_pkg.sv
// Shared constants for the 1101-framed serial transmitter: FSM state codes and sync header.
package seq1101_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] PAY  = 2'd2;
  localparam logic [1:0] PAR  = 2'd3;

  localparam logic [3:0] SYNC_PAT = 4'b1101;
  localparam int         SYNC_LEN = 4;

endpackage

// File: rtl/seq1101_stuff_ctl.sv
// Zero-stuffing history: requests a stuffed 0 whenever the last three body bits were 110.
// stuff_req is combinational from the history register; no backpressure.
module seq1101_stuff_ctl (
  input  logic clk,
  input  logic rst,
  input  logic sent_bit,
  input  logic bit_vld,
  input  logic clr,
  output logic stuff_req
);

  logic [2:0] hist;

  // The first body bit arrives on the same edge that leaves the header, so clear and shift merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 3'b000;
    end else if (bit_vld) begin
      hist <= {(clr ? 2'b00 : hist[1:0]), sent_bit};
    end else if (clr) begin
      hist <= 3'b000;
    end
  end

  assign stuff_req = (hist == 3'b110);

endmodule

// File: rtl/seq1101_tx.sv
// Frames a parallel word as 1101 header, MSB-first payload, even parity, with zero-stuffing.
// First bit one cycle after capture; in_ready only in IDLE, so a word waits for the whole frame.
module seq1101_tx
  import seq1101_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              stuff_bit
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [1:0]        state, nxt_state;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [DATA_W-1:0] shreg, nxt_shreg;
  logic              par, nxt_par;
  logic              nxt_ser, nxt_en, nxt_stuff;
  logic              bit_vld, clr, stuff_req;

  assign in_ready = (state == IDLE);
  assign clr      = (state != PAY) && (state != PAR);

  seq1101_stuff_ctl u_stuff (
    .clk       (clk),
    .rst       (rst),
    .sent_bit  (nxt_ser),
    .bit_vld   (bit_vld),
    .clr       (clr),
    .stuff_req (stuff_req)
  );

  // State names the phase of the bit currently on the line; each branch picks the next bit.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_shreg = shreg;
    nxt_par   = par;
    nxt_ser   = 1'b0;
    nxt_en    = 1'b0;
    nxt_stuff = 1'b0;
    bit_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          nxt_state = HDR;
          nxt_cnt   = '0;
          nxt_shreg = in_data;
          nxt_par   = ^in_data;
          nxt_ser   = SYNC_PAT[SYNC_LEN-1];
          nxt_en    = 1'b1;
        end
      end
      HDR: begin
        nxt_en = 1'b1;
        if (cnt == CW'(SYNC_LEN - 1)) begin
          nxt_state = PAY;
          nxt_ser   = shreg[DATA_W-1];
          nxt_shreg = {shreg[DATA_W-2:0], 1'b0};
          nxt_cnt   = CW'(DATA_W - 1);
          bit_vld   = 1'b1;
        end else begin
          nxt_ser = SYNC_PAT[2'd2 - cnt[1:0]];
          nxt_cnt = cnt + CW'(1);
        end
      end
      PAY: begin
        nxt_en  = 1'b1;
        bit_vld = 1'b1;
        if (stuff_req) begin
          nxt_stuff = 1'b1;
        end else if (cnt != '0) begin
          nxt_ser   = shreg[DATA_W-1];
          nxt_shreg = {shreg[DATA_W-2:0], 1'b0};
          nxt_cnt   = cnt - CW'(1);
        end else begin
          nxt_state = PAR;
          nxt_ser   = par;
        end
      end
      PAR: begin
        // A trailing stuff keeps the state in PAR for one more cycle; two stuffs cannot follow.
        if (stuff_req) begin
          nxt_en    = 1'b1;
          nxt_stuff = 1'b1;
          bit_vld   = 1'b1;
        end else begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      ser_out   <= 1'b0;
      ser_en    <= 1'b0;
      stuff_bit <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      shreg     <= nxt_shreg;
      par       <= nxt_par;
      ser_out   <= nxt_ser;
      ser_en    <= nxt_en;
      stuff_bit <= nxt_stuff;
    end
  end

endmodule

// File: tb/tb_seq1101_tx.sv
// Bench for seq1101_tx: frame-level reference model, per-cycle line compare, frame decoder checks.
module tb_seq1101_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, ser_out, ser_en, stuff_bit;

  always #5 clk = ~clk;

  seq1101_tx #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_en    (ser_en),
    .stuff_bit (stuff_bit)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the whole frame is built at capture time as a list of {bit, stuffed} entries.
  typedef struct packed {logic b; logic s;} ent_t;
  ent_t          q[$];
  logic [DW-1:0] words[$];

  function automatic void build(input logic [DW-1:0] w);
    logic [3:0] h;
    logic       d[$];
    logic       sent[$];
    int         n;
    h = 4'b1101;
    for (int i = 3; i >= 0; i--) q.push_back({h[i], 1'b0});
    for (int i = DW - 1; i >= 0; i--) d.push_back(w[i]);
    d.push_back(^w);
    for (int i = 0; i <= d.size(); i++) begin
      n = sent.size();
      if (n >= 3 && sent[n-3] == 1'b1 && sent[n-2] == 1'b1 && sent[n-1] == 1'b0) begin
        q.push_back({1'b0, 1'b1});
        sent.push_back(1'b0);
      end
      if (i < d.size()) begin
        q.push_back({d[i], 1'b0});
        sent.push_back(d[i]);
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      words.delete();
    end else if (q.size() > 0) begin
      q.delete(0);
    end else if (in_valid) begin
      build(in_data);
      words.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0)
      chk("line", {ser_en, ser_out, stuff_bit, in_ready}, {1'b1, q[0].b, q[0].s, 1'b0});
    else
      chk("line_idle", {ser_en, ser_out, stuff_bit, in_ready}, 4'b0001);
  end

  // Frame recorder and decoder: destuffs, checks payload/parity and scans for sync patterns.
  logic [63:0] rbits = '0, rstuff = '0, last_bits = '0, last_stuff = '0;
  int rlen = 0, gap = 0, last_gap = 0, last_len = 0, frames = 0;

  task automatic analyze();
    logic [DW-1:0] w, pay;
    logic          p;
    logic          fb[$];
    int            ns, k, det, found, i;
    ns = 0; k = 0; det = 0; found = 0; pay = '0; p = 1'b0;
    for (int j = rlen - 1; j >= 0; j--) fb.push_back(rbits[j]);
    chk("word_avail", (words.size() > 0), 1);
    if (words.size() == 0) return;
    w = words.pop_front();
    chk("header", rbits[rlen-1 -: 4], 4'b1101);
    for (int j = 4; j < rlen; j++) begin
      if (rstuff[rlen-1-j]) begin
        ns++;
        chk("stuffed_zero", fb[j], 0);
      end else begin
        if (k < DW) pay[DW-1-k] = fb[j];
        else p = fb[j];
        k++;
      end
    end
    chk("body_bits", k, DW + 1);
    chk("payload", pay, w);
    chk("parity", p, ^w);
    chk("length", rlen, 4 + DW + 1 + ns);
    chk("max_stuff", (ns <= (DW + 3) / 3), 1);
    for (int j = 4; j + 3 < rlen; j++)
      if (fb[j] && fb[j+1] && !fb[j+2] && fb[j+3]) found++;
    chk("no_sync_in_body", found, 0);
    i = 0;
    while (i + 3 < rlen) begin
      if (fb[i] && fb[i+1] && !fb[i+2] && fb[i+3]) begin det++; i += 4; end
      else i++;
    end
    chk("detector_hits", det, 1);
    last_bits = rbits; last_stuff = rstuff; last_len = rlen;
    frames++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rlen = 0; rbits = '0; rstuff = '0; gap = 0;
    end else if (ser_en) begin
      if (rlen == 0) last_gap = gap;
      rbits  = {rbits[62:0], ser_out};
      rstuff = {rstuff[62:0], stuff_bit};
      rlen++;
    end else begin
      if (rlen > 0) begin
        analyze();
        rlen = 0; rbits = '0; rstuff = '0; gap = 0;
      end
      gap++;
    end
  end

  task automatic send(input logic [DW-1:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_timeout", (n < 100), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic wait_frame();
    int f0, n;
    f0 = frames; n = 0;
    while (frames == f0 && n < 200) begin @(negedge clk); n++; end
    chk("frame_timeout", (frames != f0), 1);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, fbase, ncyc;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_line", {ser_en, ser_out, stuff_bit}, 3'b000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 8'hA5: no stuffing, ready returns in cycle 14
    send(8'hA5);
    n = 1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("a5_ready_cycle", n, 14);
    @(negedge clk);
    chk("a5_len", last_len, 13);
    chk("a5_bits", last_bits, 64'h1B4A);
    chk("a5_stuff", last_stuff, 64'h0);

    send(8'hDB);
    wait_frame();
    chk("db_len", last_len, 16);
    chk("db_bits", last_bits, 64'hDCCC);
    chk("db_stuff", last_stuff, 64'h0111);

    send(8'hFF);
    wait_frame();
    chk("ff_len", last_len, 14);
    chk("ff_bits", last_bits, 64'h37FC);
    chk("ff_stuff", last_stuff, 64'h1);

    // Back-to-back with in_valid held; in_data changes mid-frame must not matter
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    in_data = 8'h3C;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_data  = 8'h5A;
    in_valid = 1'b0;
    wait_frame();
    chk("b2b_gap", last_gap, 1);
    chk("b2b_len", last_len, 14);
    chk("b2b_bits", last_bits, 64'h34F0);
    chk("b2b_stuff", last_stuff, 64'h4);

    // Asynchronous abort during the payload of 8'hDB
    send(8'hDB);
    repeat (6) @(negedge clk);
    chk("pre_abort_en", ser_en, 1);
    fbase = frames;
    #2 rst = 1'b1;
    #1;
    chk("abort_line", {ser_en, ser_out, stuff_bit}, 3'b000);
    chk("abort_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_dropped", frames, fbase);
    send(8'hA5);
    wait_frame();
    chk("a5_again_len", last_len, 13);
    chk("a5_again_bits", last_bits, 64'h1B4A);
    chk("a5_again_stuff", last_stuff, 64'h0);

    // Random traffic with random valid gaps and churning in_data
    fbase = frames;
    ncyc = 0;
    while ((frames - fbase) < 1000 && ncyc < 60000) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      ncyc++;
    end
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("random_frames", ((frames - fbase) >= 1000), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
